// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared mode type, saturating arithmetic and default parameters for pwm_multi_gen
//  No ports. Used by pwm_channel and pwm_multi_gen; optional feature macro PWM_COMPL_EN lives in those files.
package pwm_multi_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_REF = 1'b1} mode_e;
  localparam int NCH_DEF      = 2;
  localparam int CW_DEF       = 8;
  localparam int REF_W_DEF    = 4;
  localparam int PRESC_DEF    = 1000;
  localparam int P_RST_DEF    = 99;
  localparam int P_MIN_DEF    = 3;
  localparam int STEP_DEF     = 1;
  localparam int DEADTIME_DEF = 2;
  function automatic int sat_add(input int v, input int s, input int hi);
    return (v + s > hi) ? hi : v + s;
  endfunction
  function automatic int sat_sub(input int v, input int s, input int lo);
    return (v - s < lo) ? lo : v - s;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel -- period counter, shadow-to-active transfer at wrap, compare, optional dead-time
//  Ports: clk, rst (async, active-high), i_en (enable), i_tick (shared prescaler tick),
//         i_p (shadow period code), i_de (effective duty), o_pwm (registered PWM),
//         o_pwm_n (complementary output, only when PWM_COMPL_EN is defined)
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int P_RST    = P_RST_DEF,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_tick,
  input  logic [CW-1:0] i_p,
  input  logic [CW:0]   i_de,
`ifdef PWM_COMPL_EN
  output logic          o_pwm_n,
`endif
  output logic          o_pwm
);
  logic [CW-1:0] r_cnt, r_pa;
  logic [CW:0]   r_da;
  logic          r_o, w_raw, w_load;
  // active copies track the shadows while disabled, so enabling starts with current settings
  assign w_load = !i_en || (i_tick && (r_cnt == r_pa));
  assign w_raw  = i_en && ({1'b0, r_cnt} < r_da);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_pa  <= CW'(P_RST);
      r_da  <= '0;
      r_o   <= 1'b0;
    end else begin
      r_o   <= w_raw;
      r_cnt <= w_load ? '0 : i_tick ? r_cnt + 1'b1 : r_cnt;
      if (w_load) begin
        r_pa <= i_p;
        r_da <= i_de;
      end
    end
`ifdef PWM_COMPL_EN
  localparam int DTW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  logic [DTW-1:0] r_dt;
  logic           r_en_q, w_settled;
  // r_dt counts clocks since r_o last changed; each output only rises once that has reached DEADTIME
  assign w_settled = (r_dt == DTW'(DEADTIME));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dt   <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= i_en;
      r_dt   <= (w_raw != r_o) ? '0 : w_settled ? r_dt : r_dt + 1'b1;
    end
  assign o_pwm   = r_o & w_settled;
  assign o_pwm_n = r_en_q & ~r_o & w_settled;
`else
  assign o_pwm = r_o;
`endif
endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM generator with button-set, double-buffered period/duty and REF duty mode
//  Ports: CLKNEXYS clock, MRst async active-high reset, MEn enable, Modo_i (0 manual / 1 REF duty),
//         ch_sel_i button target channel, aumC_i/bajaC_i duty up/down, aumf_i/bajaf_i frequency up/down,
//         REF reference duty fraction, numF_o selected channel period code, SALIDAM PWM outputs,
//         SALIDAM_n complementary dead-banded outputs (only when PWM_COMPL_EN is defined)
module pwm_multi_gen
  import pwm_multi_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int CW       = CW_DEF,
  parameter int REF_W    = REF_W_DEF,
  parameter int PRESC    = PRESC_DEF,
  parameter int P_RST    = P_RST_DEF,
  parameter int P_MIN    = P_MIN_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int DEADTIME = DEADTIME_DEF,
  localparam int SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLKNEXYS,
  input  logic             MRst,
  input  logic             MEn,
  input  logic             Modo_i,
  input  logic [SW-1:0]    ch_sel_i,
  input  logic             aumC_i,
  input  logic             bajaC_i,
  input  logic             aumf_i,
  input  logic             bajaf_i,
  input  logic [REF_W-1:0] REF,
  output logic [CW-1:0]    numF_o,
`ifdef PWM_COMPL_EN
  output logic [NCH-1:0]   SALIDAM_n,
`endif
  output logic [NCH-1:0]   SALIDAM
);
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int P_MAX = (1 << CW) - 1;
  logic [PW-1:0] r_ps;
  logic [3:0]    r_btn, w_rise;
  logic          w_tick, w_sel_ok, w_dup, w_ddn, w_pup, w_pdn;
  logic [CW-1:0] w_p [NCH];
  mode_e         w_mode;
  assign w_mode   = mode_e'(Modo_i);
  assign w_rise   = {aumC_i, bajaC_i, aumf_i, bajaf_i} & ~r_btn;
  // opposing presses in the same cycle cancel; aumf shortens the period
  assign w_dup    = w_rise[3] & ~w_rise[2];
  assign w_ddn    = w_rise[2] & ~w_rise[3];
  assign w_pdn    = w_rise[1] & ~w_rise[0];
  assign w_pup    = w_rise[0] & ~w_rise[1];
  assign w_sel_ok = int'(ch_sel_i) < NCH;
  assign w_tick   = MEn && (int'(r_ps) == PRESC - 1);
  assign numF_o   = w_sel_ok ? w_p[ch_sel_i] : '0;
  always_ff @(posedge CLKNEXYS or posedge MRst)
    if (MRst) begin
      r_ps  <= '0;
      r_btn <= '0;
    end else begin
      r_btn <= {aumC_i, bajaC_i, aumf_i, bajaf_i};
      r_ps  <= (!MEn || w_tick) ? '0 : r_ps + 1'b1;
    end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          w_hit;
    logic [CW-1:0] r_p, w_pn;
    logic [CW:0]   r_d, w_de;
    int            w_lim, w_dv, w_ref;
    assign w_hit  = w_sel_ok && (int'(ch_sel_i) == g);
    assign w_pn   = !w_hit ? r_p
                  : w_pdn  ? CW'(sat_sub(int'(r_p), STEP, P_MIN))
                  : w_pup  ? CW'(sat_add(int'(r_p), STEP, P_MAX)) : r_p;
    // duty is bounded by the new period, so shrinking P drags D down in the same cycle
    assign w_lim  = int'(w_pn) + 1;
    assign w_dv   = (w_hit && w_dup) ? sat_add(int'(r_d), STEP, w_lim)
                  : (w_hit && w_ddn) ? sat_sub(int'(r_d), STEP, 0) : int'(r_d);
    assign w_ref  = ((int'(r_p) + 1) * int'(REF)) >> REF_W;
    assign w_de   = (w_mode == MODE_REF) ? (CW+1)'(w_ref) : r_d;
    assign w_p[g] = r_p;
    always_ff @(posedge CLKNEXYS or posedge MRst)
      if (MRst) begin
        r_p <= CW'(P_RST);
        r_d <= '0;
      end else begin
        r_p <= w_pn;
        r_d <= (CW+1)'((w_dv > w_lim) ? w_lim : w_dv);
      end
    pwm_channel #(.CW(CW), .P_RST(P_RST), .DEADTIME(DEADTIME)) u_ch (
      .clk    (CLKNEXYS),
      .rst    (MRst),
      .i_en   (MEn),
      .i_tick (w_tick),
      .i_p    (r_p),
      .i_de   (w_de),
`ifdef PWM_COMPL_EN
      .o_pwm_n(SALIDAM_n[g]),
`endif
      .o_pwm  (SALIDAM[g])
    );
  end
endmodule
